io_word_bridge: RTL and testbench
=================================

// Module: io_word_bridge
// PURPOSE
//  CPU-side adapter between the core's I/O instructions and the UART IOcontroller byte streams.
//  Turns each CPU in/out request (1 byte or 4-byte word) into that many byte handshakes.
//  Returns one response per request: read data for inputs, a completion ack for outputs.
//  Sits between the core's I/O unit and IOcontroller (io_in_* / io_out_*).
// PARAMETERS
//  BIG_ENDIAN    1  1: word bytes sent/received [31:24] first; 0: [7:0] first
//  SIGN_EXT_BYTE 0  1: byte-input result sign-extended from bit 7; 0: zero-extended
// PORTS
//  clk            in   1   clock, single domain
//  rstn           in   1   synchronous active-low reset
//  cpu_req_vld    in   1   CPU request valid
//  cpu_req_rdy    out  1   bridge can accept a request (IDLE only)
//  cpu_req_wr     in   1   1=output (write to UART), 0=input (read from UART)
//  cpu_req_word   in   1   1=4 bytes, 0=1 byte
//  cpu_req_data   in   32  output data (byte mode: [7:0] used)
//  cpu_resp_vld   out  1   response valid
//  cpu_resp_rdy   in   1   CPU accepts response
//  cpu_resp_data  out  32  input result; 32'h0 for output acks
//  io_in_data     in   8   byte from IOcontroller receive buffer
//  io_in_vld      in   1   receive byte valid
//  io_in_rdy      out  1   bridge takes receive byte
//  io_out_data    out  8   byte to IOcontroller transmit buffer
//  io_out_rdy     in   1   transmit buffer has room
//  io_out_vld     out  1   bridge offers transmit byte
// BEHAVIOUR
//  - Fire = vld && rdy in the same cycle, on every channel. No combinational path from
//    io_*_vld/rdy to io_*_rdy/vld. Peer may raise/drop its side at any cycle.
//  - Reset (rstn=0 at posedge): state=IDLE, cnt=0, shreg=0. cpu_req_rdy=1, cpu_resp_vld=0,
//    cpu_resp_data=0, io_in_rdy=0, io_out_vld=0, io_out_data=0.
//    Reset mid-transfer drops the request; bytes already handshaken are not recovered.
//  - States: IDLE, IN, OUT, RESP.
//  - IDLE: cpu_req_rdy=1. On request fire:
//      nbytes = word ? 4 : 1; cnt = nbytes-1.
//      wr=1 -> load shreg (byte mode: data[7:0] into the first-sent lane), go to OUT.
//      wr=0 -> clear shreg, go to IN.
//  - OUT: io_out_vld=1 from the first cycle after accept.
//      io_out_data = current lane (BIG_ENDIAN: shreg[31:24], else shreg[7:0]).
//      Data is held stable while vld=1 and rdy=0.
//      On fire: shift shreg 8 bits; if cnt==0, drop vld, go to RESP with data 0; else cnt-1.
//  - IN: io_in_rdy=1.
//      On fire, BIG_ENDIAN: shreg={shreg[23:0],byte}; else shreg={byte,shreg[31:8]}.
//      When cnt==0 after a fire: drop rdy, go to RESP. Result is shreg (word),
//      or {24{SIGN_EXT_BYTE & b[7]}, b} (byte).
//  - RESP: cpu_resp_vld=1, cpu_resp_data held until cpu_resp_rdy.
//      On fire: go to IDLE, cpu_req_rdy=1 next cycle.
//  - Latency:
//      output: accept at T, first byte offered T+1; back-to-back fires give resp_vld at T+1+n.
//      input (bytes waiting): rdy at T+1, resp_vld at T+1+n.
//  - cpu_req_rdy is 0 outside IDLE: one outstanding request, no pipelining.
//  - Starvation: IN waits indefinitely on empty receive buffer; no timeout.
//  - io_in_rdy and io_out_vld are never both 1.
//  - cnt is 2 bits; it never wraps, because exit occurs on cnt==0.
// STRUCTURE
//  - Shared package io_pkg: state encoding (IDLE/IN/OUT/RESP), BYTES_PER_WORD=4, BYTE_W=8.
//    IOcontroller and this block share the byte width from io_pkg.
//  - Single module, no sub-module: one 32-bit shift register + 2-bit counter + FSM.
// TESTING
//  - Word out, BIG_ENDIAN=1, data 32'h11223344, io_out_rdy=1
//    -> bytes 11,22,33,44 on 4 consecutive cycles; resp_vld 1 cycle later, data 0.
//  - Word in, bytes A1,B2,C3,D4 with io_in_vld gaps of 2 cycles -> resp_data 32'hA1B2C3D4.
//    Same stimulus with BIG_ENDIAN=0 -> 32'hD4C3B2A1.
//  - Byte in 8'hF0: SIGN_EXT_BYTE=0 -> 32'h000000F0; SIGN_EXT_BYTE=1 -> 32'hFFFFFFF0.
//  - Output backpressure: io_out_rdy low 5 cycles on byte 2 -> io_out_data stable at 22,
//    no duplicate or lost byte.
//  - cpu_resp_rdy low 3 cycles -> resp held, cpu_req_rdy=0, and a second request is not
//    accepted until the response fires.
//  - rstn low during 3rd byte of word out -> all outputs at reset values next cycle.
//    A fresh byte request after reset completes normally.

Source files
------------

// File: rtl/io_pkg.sv
// Shared definitions for the UART I/O path: byte/word geometry and bridge state encoding.
// IOcontroller and io_word_bridge both take their byte width from here.
package io_pkg;

    localparam int BYTE_W         = 8;
    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_W         = BYTE_W * BYTES_PER_WORD;
    localparam int CNT_W          = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_IN   = 2'd1,
        ST_OUT  = 2'd2,
        ST_RESP = 2'd3
    } io_state_t;

    // Remaining-byte counter load value: the transfer ends on the fire that sees zero.
    function automatic logic [CNT_W-1:0] first_cnt(input logic word);
        return word ? CNT_W'(BYTES_PER_WORD - 1) : '0;
    endfunction

endpackage

// File: rtl/io_word_bridge.sv
// Adapts CPU in/out requests (byte or 32-bit word) into byte handshakes on the
// IOcontroller receive/transmit streams, returning one response per request.
module io_word_bridge
    import io_pkg::*;
#(
    parameter bit BIG_ENDIAN    = 1'b1,
    parameter bit SIGN_EXT_BYTE = 1'b0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cpu_req_vld,
    output logic              cpu_req_rdy,
    input  logic              cpu_req_wr,
    input  logic              cpu_req_word,
    input  logic [WORD_W-1:0] cpu_req_data,
    output logic              cpu_resp_vld,
    input  logic              cpu_resp_rdy,
    output logic [WORD_W-1:0] cpu_resp_data,
    input  logic [BYTE_W-1:0] io_in_data,
    input  logic              io_in_vld,
    output logic              io_in_rdy,
    output logic [BYTE_W-1:0] io_out_data,
    input  logic              io_out_rdy,
    output logic              io_out_vld
);

    io_state_t         state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [WORD_W-1:0] shreg_reg, shreg_next;
    logic [WORD_W-1:0] resp_data_reg, resp_data_next;
    logic              word_reg, word_next;

    logic [WORD_W-1:0] shreg_in;
    logic [WORD_W-1:0] shreg_shifted;
    logic [WORD_W-1:0] byte_load;
    logic [WORD_W-1:0] byte_result;
    logic [BYTE_W-1:0] out_lane;

    // The first-transferred lane is the top byte in big-endian order, the bottom byte otherwise.
    always_comb begin
        if (BIG_ENDIAN) begin
            shreg_in      = {shreg_reg[WORD_W-BYTE_W-1:0], io_in_data};
            shreg_shifted = {shreg_reg[WORD_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
            byte_load     = {cpu_req_data[BYTE_W-1:0], {(WORD_W-BYTE_W){1'b0}}};
            out_lane      = shreg_reg[WORD_W-1 -: BYTE_W];
        end else begin
            shreg_in      = {io_in_data, shreg_reg[WORD_W-1:BYTE_W]};
            shreg_shifted = {{BYTE_W{1'b0}}, shreg_reg[WORD_W-1:BYTE_W]};
            byte_load     = {{(WORD_W-BYTE_W){1'b0}}, cpu_req_data[BYTE_W-1:0]};
            out_lane      = shreg_reg[BYTE_W-1:0];
        end
        byte_result = {{(WORD_W-BYTE_W){SIGN_EXT_BYTE & io_in_data[BYTE_W-1]}}, io_in_data};
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        shreg_next     = shreg_reg;
        resp_data_next = resp_data_reg;
        word_next      = word_reg;

        case (state_reg)
            ST_IDLE: begin
                if (cpu_req_vld) begin
                    cnt_next  = first_cnt(cpu_req_word);
                    word_next = cpu_req_word;
                    if (cpu_req_wr) begin
                        shreg_next = cpu_req_word ? cpu_req_data : byte_load;
                        state_next = ST_OUT;
                    end else begin
                        shreg_next = '0;
                        state_next = ST_IN;
                    end
                end
            end
            ST_OUT: begin
                if (io_out_rdy) begin
                    shreg_next = shreg_shifted;
                    if (cnt_reg == '0) begin
                        resp_data_next = '0;
                        state_next     = ST_RESP;
                    end else begin
                        cnt_next = cnt_reg - 1'b1;
                    end
                end
            end
            ST_IN: begin
                if (io_in_vld) begin
                    shreg_next = shreg_in;
                    if (cnt_reg == '0) begin
                        resp_data_next = word_reg ? shreg_in : byte_result;
                        state_next     = ST_RESP;
                    end else begin
                        cnt_next = cnt_reg - 1'b1;
                    end
                end
            end
            ST_RESP: begin
                if (cpu_resp_rdy) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            shreg_reg     <= '0;
            resp_data_reg <= '0;
            word_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            shreg_reg     <= shreg_next;
            resp_data_reg <= resp_data_next;
            word_reg      <= word_next;
        end
    end

    // Handshake outputs depend only on registered state, so peers never see a loop back.
    assign cpu_req_rdy   = (state_reg == ST_IDLE);
    assign cpu_resp_vld  = (state_reg == ST_RESP);
    assign cpu_resp_data = resp_data_reg;
    assign io_in_rdy     = (state_reg == ST_IN);
    assign io_out_vld    = (state_reg == ST_OUT);
    assign io_out_data   = (state_reg == ST_OUT) ? out_lane : '0;

endmodule

// File: tb/tb_io_word_bridge.sv
// Directed plus randomized check of io_word_bridge in two configurations
// (big-endian/zero-extend and little-endian/sign-extend) driven in lockstep.
module tb_io_word_bridge;

    logic        clk = 1'b0;
    logic        rstn;
    logic        cpu_req_vld;
    logic        cpu_req_wr;
    logic        cpu_req_word;
    logic [31:0] cpu_req_data;
    logic        cpu_resp_rdy;
    logic [7:0]  io_in_data;
    logic        io_in_vld;
    logic        io_out_rdy;

    logic        be_req_rdy, be_resp_vld, be_in_rdy, be_out_vld;
    logic [31:0] be_resp_data;
    logic [7:0]  be_out_data;
    logic        le_req_rdy, le_resp_vld, le_in_rdy, le_out_vld;
    logic [31:0] le_resp_data;
    logic [7:0]  le_out_data;

    int errors = 0;
    int checks = 0;
    int txn    = 0;

    always #5 clk = ~clk;

    io_word_bridge #(.BIG_ENDIAN(1'b1), .SIGN_EXT_BYTE(1'b0)) u_be (
        .clk(clk), .rstn(rstn),
        .cpu_req_vld(cpu_req_vld), .cpu_req_rdy(be_req_rdy), .cpu_req_wr(cpu_req_wr),
        .cpu_req_word(cpu_req_word), .cpu_req_data(cpu_req_data),
        .cpu_resp_vld(be_resp_vld), .cpu_resp_rdy(cpu_resp_rdy), .cpu_resp_data(be_resp_data),
        .io_in_data(io_in_data), .io_in_vld(io_in_vld), .io_in_rdy(be_in_rdy),
        .io_out_data(be_out_data), .io_out_rdy(io_out_rdy), .io_out_vld(be_out_vld)
    );

    io_word_bridge #(.BIG_ENDIAN(1'b0), .SIGN_EXT_BYTE(1'b1)) u_le (
        .clk(clk), .rstn(rstn),
        .cpu_req_vld(cpu_req_vld), .cpu_req_rdy(le_req_rdy), .cpu_req_wr(cpu_req_wr),
        .cpu_req_word(cpu_req_word), .cpu_req_data(cpu_req_data),
        .cpu_resp_vld(le_resp_vld), .cpu_resp_rdy(cpu_resp_rdy), .cpu_resp_data(le_resp_data),
        .io_in_data(io_in_data), .io_in_vld(io_in_vld), .io_in_rdy(le_in_rdy),
        .io_out_data(le_out_data), .io_out_rdy(io_out_rdy), .io_out_vld(le_out_vld)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: k-th byte put on the wire for an output request.
    function automatic logic [7:0] out_byte(input bit be, input logic word, input logic [31:0] d, input int k);
        if (!word) return d[7:0];
        if (be) return 8'(d >> (8 * (3 - k)));
        return 8'(d >> (8 * k));
    endfunction

    // Reference: response for an input request; b[0] is the first byte received.
    function automatic logic [31:0] in_result(input bit be, input bit sx, input logic word,
                                              input logic [3:0][7:0] b);
        logic [7:0] b0;
        b0 = b[0];
        if (!word) return (sx && b0[7]) ? {24'hFFFFFF, b0} : {24'h0, b0};
        if (be) return {b[0], b[1], b[2], b[3]};
        return {b[3], b[2], b[1], b[0]};
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_be_req_rdy"}, 32'(be_req_rdy), 32'd1);
        check({tag, "_le_req_rdy"}, 32'(le_req_rdy), 32'd1);
        check({tag, "_be_resp_vld"}, 32'(be_resp_vld), 32'd0);
        check({tag, "_le_resp_vld"}, 32'(le_resp_vld), 32'd0);
        check({tag, "_be_resp_data"}, be_resp_data, 32'd0);
        check({tag, "_le_resp_data"}, le_resp_data, 32'd0);
        check({tag, "_in_rdy"}, {30'd0, be_in_rdy, le_in_rdy}, 32'd0);
        check({tag, "_out_vld"}, {30'd0, be_out_vld, le_out_vld}, 32'd0);
        check({tag, "_out_data"}, {16'd0, be_out_data, le_out_data}, 32'd0);
    endtask

    task automatic send_req(input logic wr, input logic word, input logic [31:0] data);
        int budget = 20;
        while (be_req_rdy !== 1'b1 && budget > 0) begin
            tick();
            budget--;
        end
        check("req_rdy_before", {30'd0, be_req_rdy, le_req_rdy}, 32'd3);
        cpu_req_vld  = 1'b1;
        cpu_req_wr   = wr;
        cpu_req_word = word;
        cpu_req_data = data;
        tick();
        cpu_req_vld  = 1'b0;
        cpu_req_data = $urandom;
        check("req_rdy_after", {30'd0, be_req_rdy, le_req_rdy}, 32'd0);
    endtask

    task automatic run_out(input logic word, input logic [31:0] data, input int stall_byte,
                           input int stall_len, input bit rnd, input int abort_at);
        int n = word ? 4 : 1;
        int k = 0;
        int stalled = 0;
        int budget = 100;
        bit rdy;
        while (k < n && budget > 0) begin
            check("out_vld", {30'd0, be_out_vld, le_out_vld}, 32'd3);
            check("out_in_rdy", {30'd0, be_in_rdy, le_in_rdy}, 32'd0);
            check("out_be_data", 32'(be_out_data), 32'(out_byte(1'b1, word, data, k)));
            check("out_le_data", 32'(le_out_data), 32'(out_byte(1'b0, word, data, k)));
            if (k == abort_at) begin
                rstn = 1'b0;
                io_out_rdy = 1'b1;
                tick();
                check_reset_outputs("mid_reset");
                rstn = 1'b1;
                io_out_rdy = 1'b0;
                return;
            end
            if (k == stall_byte && stalled < stall_len) begin
                rdy = 1'b0;
                stalled++;
            end else if (rnd) begin
                rdy = ($urandom_range(0, 3) != 0);
            end else begin
                rdy = 1'b1;
            end
            io_out_rdy = rdy;
            tick();
            if (rdy) k++;
            budget--;
        end
        check("out_bytes_done", 32'(k), 32'(n));
        io_out_rdy = 1'($urandom_range(0, 1));
    endtask

    task automatic run_in(input logic word, input logic [3:0][7:0] bytes, input int gap, input bit rnd);
        int n = word ? 4 : 1;
        int k = 0;
        int wait_cnt = gap;
        int budget = 200;
        bit offer;
        while (k < n && budget > 0) begin
            check("in_rdy", {30'd0, be_in_rdy, le_in_rdy}, 32'd3);
            check("in_out_vld", {30'd0, be_out_vld, le_out_vld}, 32'd0);
            check("in_resp_vld", {30'd0, be_resp_vld, le_resp_vld}, 32'd0);
            offer = rnd ? ($urandom_range(0, 2) != 0) : (wait_cnt == 0);
            io_in_vld  = offer;
            io_in_data = offer ? bytes[k] : 8'($urandom);
            tick();
            if (offer) begin
                k++;
                wait_cnt = gap;
            end else begin
                wait_cnt--;
            end
            budget--;
        end
        check("in_bytes_done", 32'(k), 32'(n));
        // A byte offered while the bridge is responding must not be consumed.
        io_in_vld  = 1'b1;
        io_in_data = 8'hEE;
    endtask

    task automatic finish_resp(input int hold, input logic [31:0] exp_be, input logic [31:0] exp_le);
        check("resp_vld", {30'd0, be_resp_vld, le_resp_vld}, 32'd3);
        check("resp_be_data", be_resp_data, exp_be);
        check("resp_le_data", le_resp_data, exp_le);
        check("resp_req_rdy", {30'd0, be_req_rdy, le_req_rdy}, 32'd0);
        check("resp_io_idle", {28'd0, be_in_rdy, le_in_rdy, be_out_vld, le_out_vld}, 32'd0);
        for (int i = 0; i < hold; i++) begin
            cpu_resp_rdy = 1'b0;
            cpu_req_vld  = 1'b1;
            cpu_req_wr   = 1'b1;
            cpu_req_word = 1'b0;
            tick();
            check("hold_resp_vld", {30'd0, be_resp_vld, le_resp_vld}, 32'd3);
            check("hold_be_data", be_resp_data, exp_be);
            check("hold_le_data", le_resp_data, exp_le);
            check("hold_req_rdy", {30'd0, be_req_rdy, le_req_rdy}, 32'd0);
        end
        cpu_req_vld  = 1'b0;
        cpu_resp_rdy = 1'b1;
        tick();
        cpu_resp_rdy = 1'b0;
        io_in_vld    = 1'b0;
        io_out_rdy   = 1'b0;
        check("post_resp_vld", {30'd0, be_resp_vld, le_resp_vld}, 32'd0);
        check("post_req_rdy", {30'd0, be_req_rdy, le_req_rdy}, 32'd3);
        txn++;
        $display("txn %0d: be_resp=%h le_resp=%h (expected %h / %h)",
                 txn, be_resp_data, le_resp_data, exp_be, exp_le);
    endtask

    initial begin
        logic [3:0][7:0] bytes;
        logic [31:0]     data;
        logic            wr, word;

        rstn = 1'b0;
        cpu_req_vld = 1'b0; cpu_req_wr = 1'b0; cpu_req_word = 1'b0; cpu_req_data = 32'h0;
        cpu_resp_rdy = 1'b0; io_in_data = 8'h0; io_in_vld = 1'b0; io_out_rdy = 1'b0;
        tick();
        tick();
        check_reset_outputs("reset");
        rstn = 1'b1;

        // Word out, unstalled: four back-to-back bytes then an ack of zero.
        send_req(1'b1, 1'b1, 32'h11223344);
        run_out(1'b1, 32'h11223344, -1, 0, 1'b0, -1);
        finish_resp(0, 32'h0, 32'h0);

        // Word in with two idle cycles before each byte.
        bytes = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
        send_req(1'b0, 1'b1, 32'h0);
        run_in(1'b1, bytes, 2, 1'b0);
        check("word_in_be_literal", be_resp_data, 32'hA1B2C3D4);
        check("word_in_le_literal", le_resp_data, 32'hD4C3B2A1);
        finish_resp(0, in_result(1'b1, 1'b0, 1'b1, bytes), in_result(1'b0, 1'b1, 1'b1, bytes));

        // Byte in with bit 7 set: zero- vs sign-extension.
        bytes = {24'h0, 8'hF0};
        send_req(1'b0, 1'b0, 32'h0);
        run_in(1'b0, bytes, 0, 1'b0);
        check("byte_in_zext_literal", be_resp_data, 32'h000000F0);
        check("byte_in_sext_literal", le_resp_data, 32'hFFFFFFF0);
        finish_resp(0, in_result(1'b1, 1'b0, 1'b0, bytes), in_result(1'b0, 1'b1, 1'b0, bytes));

        // Transmit backpressure for five cycles on the second byte.
        send_req(1'b1, 1'b1, 32'h11223344);
        run_out(1'b1, 32'h11223344, 1, 5, 1'b0, -1);
        finish_resp(0, 32'h0, 32'h0);

        // Response held for three cycles while a second request is pending.
        send_req(1'b1, 1'b0, 32'hDEADBE5A);
        run_out(1'b0, 32'hDEADBE5A, -1, 0, 1'b0, -1);
        finish_resp(3, 32'h0, 32'h0);

        // Reset during the third byte of a word out, then fresh byte requests.
        send_req(1'b1, 1'b1, 32'hCAFEF00D);
        run_out(1'b1, 32'hCAFEF00D, -1, 0, 1'b0, 2);
        send_req(1'b1, 1'b0, 32'h0000003C);
        run_out(1'b0, 32'h0000003C, -1, 0, 1'b0, -1);
        finish_resp(0, 32'h0, 32'h0);
        bytes = {24'h0, 8'h81};
        send_req(1'b0, 1'b0, 32'h0);
        run_in(1'b0, bytes, 1, 1'b0);
        finish_resp(1, in_result(1'b1, 1'b0, 1'b0, bytes), in_result(1'b0, 1'b1, 1'b0, bytes));

        // Randomized requests with random peer stalls and response holds.
        for (int t = 0; t < 24; t++) begin
            wr    = 1'($urandom_range(0, 1));
            word  = 1'($urandom_range(0, 1));
            data  = $urandom;
            bytes = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
            send_req(wr, word, data);
            if (wr) begin
                run_out(word, data, -1, 0, 1'b1, -1);
                finish_resp($urandom_range(0, 2), 32'h0, 32'h0);
            end else begin
                run_in(word, bytes, 0, 1'b1);
                finish_resp($urandom_range(0, 2), in_result(1'b1, 1'b0, word, bytes),
                            in_result(1'b0, 1'b1, word, bytes));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
